// File: rtl/alu_serial_driver_pkg.sv
// Shared definitions for the bit-serial ALU front end: opcodes and driver FSM states.
// Imported by the driver, its sub-module, the interface and the bench.
package alu_serial_driver_pkg;

  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned DEF_W    = 8;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_OR    = 3'd2,
    OP_AND   = 3'd3,
    OP_XOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_CMPA  = 3'd6,
    OP_PASSB = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SHIFT = 3'd2,
    ST_FLAG  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/alu_serial_driver_if.sv
// Request/response handshake bundle between the sequencer and the serial ALU driver.
//   Request : in_valid/in_ready, in_op, in_a, in_b
//   Response: out_valid/out_ready, out_y, out_c
//   master = sequencer side, slave = driver side.
interface alu_serial_driver_if #(
  parameter int unsigned W = 8
) ();
  import alu_serial_driver_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [ALU_OP_W-1:0] in_op;
  logic [W-1:0]        in_a;
  logic [W-1:0]        in_b;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        out_y;
  logic                out_c;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_y, out_c
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_y, out_c
  );

endinterface

// File: rtl/alu_serial_driver_shreg.sv
// W-bit register with parallel load and right shift (serial in at the MSB, serial out at q[0]).
//   clk, rst_n : clock, async active-low reset (clears to 0)
//   load, d    : parallel load (has priority over shift)
//   shift, sin : shift right, sin enters at bit W-1
//   q          : register contents
module alu_serial_driver_shreg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  input  logic         sin,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {sin, q[W-1:1]};
    end
  end

endmodule

// File: rtl/alu_serial_driver.sv
// Parallel-to-serial front end for the bit-serial ALU. Accepts an opcode and operand pair,
// clears the ALU, streams A/B LSB-first, collects y LSB-first plus the final c flag and
// returns the assembled word over a valid/ready response.
//   clk, rst_n      : clock, async active-low reset
//   bus (slave)     : in_valid/in_ready/in_op/in_a/in_b, out_valid/out_ready/out_y/out_c
//   alu_rst_n       : ALU state clear (active-low), high only in SHIFT and FLAG
//   alu_opcode      : last accepted opcode
//   alu_a, alu_b    : serial operand bits, zero outside SHIFT
//   alu_y, alu_c    : serial result bit and flag from the ALU
module alu_serial_driver
  import alu_serial_driver_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_serial_driver_if.slave  bus,
  output logic                alu_rst_n,
  output logic [ALU_OP_W-1:0] alu_opcode,
  output logic                alu_a,
  output logic                alu_b,
  input  logic                alu_y,
  input  logic                alu_c
);

  localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

  state_e         state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic           accept, shift_en, flag_en;
  logic           in_ready_d, out_valid_d, alu_rst_n_d, alu_a_d, alu_b_d;
  logic           in_ready_q, out_valid_q;
  logic [W-1:0]   a_q, b_q, y_q;
  logic [W-1:0]   out_y_q;
  logic           out_c_q;

  // Only the two low operand bits feed the serial outputs; upper bits just move down.
  logic unused_hi;
  assign unused_hi = ^{a_q[W-1:2], b_q[W-1:2]};

  // Operand and result shift registers.
  alu_serial_driver_shreg #(.W(W)) u_sh_a (
    .clk(clk), .rst_n(rst_n), .load(accept), .shift(shift_en),
    .d(bus.in_a), .sin(1'b0), .q(a_q)
  );
  alu_serial_driver_shreg #(.W(W)) u_sh_b (
    .clk(clk), .rst_n(rst_n), .load(accept), .shift(shift_en),
    .d(bus.in_b), .sin(1'b0), .q(b_q)
  );
  alu_serial_driver_shreg #(.W(W)) u_sh_y (
    .clk(clk), .rst_n(rst_n), .load(1'b0), .shift(shift_en),
    .d('0), .sin(alu_y), .q(y_q)
  );

  // State and bit-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next state plus next values of the registered outputs, decoded from the next state.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    accept   = 1'b0;
    shift_en = 1'b0;
    flag_en  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (cnt == CNT_W'(W - 1)) begin
          state_d = ST_FLAG;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_FLAG: begin
        flag_en = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    alu_rst_n_d = (state_d == ST_SHIFT) || (state_d == ST_FLAG);
    alu_a_d     = 1'b0;
    alu_b_d     = 1'b0;
    // The serial bit for the coming cycle is bit 1 if this edge shifts, else bit 0.
    if (state_d == ST_SHIFT) begin
      alu_a_d = shift_en ? a_q[1] : a_q[0];
      alu_b_d = shift_en ? b_q[1] : b_q[0];
    end
  end

  // Registered control, serial and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      alu_rst_n   <= 1'b0;
      alu_a       <= 1'b0;
      alu_b       <= 1'b0;
      alu_opcode  <= '0;
      out_y_q     <= '0;
      out_c_q     <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      alu_rst_n   <= alu_rst_n_d;
      alu_a       <= alu_a_d;
      alu_b       <= alu_b_d;
      if (accept) begin
        alu_opcode <= bus.in_op;
      end
      if (flag_en) begin
        out_y_q <= y_q;
        out_c_q <= alu_c;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_c     = out_c_q;

endmodule

// File: tb/tb_alu_serial_driver.sv
// Bench for alu_serial_driver with a behavioural bit-serial ALU attached. Expected results
// come from a word-level reference pushed to a queue at request time and popped at response.
module tb_alu_serial_driver;
  import alu_serial_driver_pkg::*;

  localparam int unsigned W = 8;

  logic                clk;
  logic                rst_n;
  logic                alu_rst_n;
  logic [ALU_OP_W-1:0] alu_opcode;
  logic                alu_a, alu_b, alu_y, alu_c;

  int total = 0;
  int bad   = 0;
  logic [W:0] exp_q[$];

  alu_serial_driver_if #(.W(W)) bus ();

  alu_serial_driver #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_rst_n(alu_rst_n), .alu_opcode(alu_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_c(alu_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural serial ALU: cy = carry / borrow / A>B, fl = OR / any-zero / parity / not-equal.
  logic cy, fl;
  always_ff @(posedge clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      cy <= 1'b0;
      fl <= 1'b0;
    end else begin
      case (alu_op_e'(alu_opcode))
        OP_ADD:  cy <= (alu_a & alu_b) | (alu_a & cy) | (alu_b & cy);
        OP_SUB:  cy <= (~alu_a & alu_b) | (~(alu_a ^ alu_b) & cy);
        OP_CMPA: cy <= (alu_a & ~alu_b) | (~(alu_a ^ alu_b) & cy);
        OP_OR:   fl <= fl | alu_a;
        OP_AND:  fl <= fl | ~alu_a;
        OP_XOR:  fl <= fl ^ alu_a;
        OP_XNOR: fl <= fl | (alu_a ^ alu_b);
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_y = 1'b0;
    alu_c = 1'b0;
    case (alu_op_e'(alu_opcode))
      OP_ADD:   begin alu_y = alu_a ^ alu_b ^ cy; alu_c = cy;  end
      OP_SUB:   begin alu_y = alu_a ^ alu_b ^ cy; alu_c = 1'b0; end
      OP_OR:    begin alu_y = alu_a | alu_b;      alu_c = fl;  end
      OP_AND:   begin alu_y = alu_a & alu_b;      alu_c = ~fl; end
      OP_XOR:   begin alu_y = alu_a ^ alu_b;      alu_c = fl;  end
      OP_XNOR:  begin alu_y = ~(alu_a ^ alu_b);   alu_c = ~fl; end
      OP_CMPA:  begin alu_y = alu_a;              alu_c = cy;  end
      default:  begin alu_y = alu_b;              alu_c = 1'b0; end
    endcase
  end

  // Word-level reference: {c, y}.
  function automatic logic [W:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [W:0] s;
    case (op)
      3'd0: s = {1'b0, a} + {1'b0, b};
      3'd1: s = {1'b0, W'(a - b)};
      3'd2: s = {|a, a | b};
      3'd3: s = {&a, a & b};
      3'd4: s = {^a, a ^ b};
      3'd5: s = {a == b, ~(a ^ b)};
      3'd6: s = {a > b, a};
      default: s = {1'b0, b};
    endcase
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait (bounded) for acceptance, and push its expected result.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    exp_q.push_back(ref_op(op, a, b));
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      step();
      guard++;
    end
    check("accept_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("clear_alu_rst_n", 32'(alu_rst_n), 32'd0);
    check("clear_in_ready", 32'(bus.in_ready), 32'd0);
    check("alu_opcode", 32'(alu_opcode), 32'(op));
  endtask

  // Wait (bounded) for the response, check latency and value, optionally stall, then release.
  task automatic collect(input int hold);
    int lat;
    logic [W:0] e;
    bus.out_ready = (hold == 0);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      step();
      lat++;
      if (lat == 2) check("shift_alu_rst_n", 32'(alu_rst_n), 32'd1);
    end
    check("latency", 32'(lat), 32'd11);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("out_y", 32'(bus.out_y), 32'(e[W-1:0]));
    check("out_c", 32'(bus.out_c), 32'(e[W]));
    check("done_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_y", 32'(bus.out_y), 32'(e[W-1:0]));
      check("hold_c", 32'(bus.out_c), 32'(e[W]));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    step();
    check("release_valid", 32'(bus.out_valid), 32'd0);
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [W:0] drop;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (3) step();

    // Reset state.
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_y", 32'(bus.out_y), 32'd0);
    check("rst_out_c", 32'(bus.out_c), 32'd0);
    check("rst_alu_rst_n", 32'(alu_rst_n), 32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("rst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
    rst_n = 1'b1;
    step();

    // Directed operations.
    send(OP_ADD, 8'hC8, 8'h64);   collect(0);
    send(OP_SUB, 8'h05, 8'h07);   collect(0);
    send(OP_CMPA, 8'h80, 8'h7F);  collect(0);
    send(OP_XNOR, 8'h5A, 8'h5A);  collect(0);
    send(OP_OR, 8'h00, 8'h3C);    collect(0);
    send(OP_AND, 8'hF0, 8'hFF);   collect(0);
    send(OP_XOR, 8'h07, 8'h0F);   collect(0);
    send(OP_PASSB, 8'h11, 8'hA5); collect(0);

    // Consumer stall for 5 cycles in DONE.
    send(OP_ADD, 8'h12, 8'h34);   collect(5);

    // Back-to-back: carry-producing add then zero add.
    send(OP_ADD, 8'hFF, 8'h01);   collect(0);
    send(OP_ADD, 8'h00, 8'h00);   collect(0);

    // A few random operations.
    for (int i = 0; i < 6; i++) begin
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      collect(0);
    end

    // Reset in the middle of SHIFT (bit 3).
    send(OP_ADD, 8'h33, 8'h44);
    repeat (4) step();
    check("mid_shift_alu_rst_n", 32'(alu_rst_n), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_alu_rst_n", 32'(alu_rst_n), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
    drop = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("post_rst_no_valid", 32'(bus.out_valid), 32'd0);
    end
    send(OP_ADD, 8'h01, 8'h01);   collect(0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
